fir_rns_pipe: RTL and testbench



---
 rtl/rns_pkg.sv | 34 +++
 rtl/rns_mac_lane.sv | 31 +++
 rtl/fir_rns_pipe.sv | 125 ++++++++++++
 tb/tb_fir_rns_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared RNS definitions: channel moduli, FIR control states and modular helpers.
package rns_pkg;

    localparam int unsigned NUM_MODULI = 8;

    // Channel i of a packed RNS word always uses MODULI[i].
    localparam int unsigned MODULI [NUM_MODULI] = '{233, 239, 241, 251, 229, 227, 223, 211};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Operands are assumed already reduced below m, so one conditional subtract is enough.
    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] m);
        logic [32:0] s;
        s = 33'(a) + 33'(b);
        if (s >= 33'(m)) begin
            s = s - 33'(m);
        end
        return 32'(s);
    endfunction

    // Full-width product reduced mod m.
    function automatic logic [31:0] mod_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] m);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return 32'(p % 64'(m));
    endfunction

endpackage

// File: rtl/rns_mac_lane.sv
// One residue channel of the FIR: modular multiply-accumulate with a fixed modulus M.
module rns_mac_lane
    import rns_pkg::*;
#(
    parameter int unsigned RW = 8,
    parameter int unsigned M  = 233
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic [RW-1:0] x,
    input  logic [RW-1:0] c,
    output logic [RW-1:0] acc_next
);

    logic [RW-1:0] acc_q;

    // Value the accumulator takes after this tap; the top samples it on the last tap.
    assign acc_next = RW'(mod_add(32'(acc_q), mod_mul(32'(x), 32'(c), M), M));

    // Accumulator: cleared on reset and on sample acceptance, advanced once per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/fir_rns_pipe.sv
// Streaming RNS FIR: all residue channels in parallel, one tap per cycle, valid/ready I/O.
module fir_rns_pipe
    import rns_pkg::*;
#(
    parameter int unsigned TAPS = 6,
    parameter int unsigned CH   = 4,
    parameter int unsigned RW   = 8,
    parameter int unsigned AW   = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coef_we,
    input  logic [AW-1:0]    coef_addr,
    input  logic [CH*RW-1:0] coef_rns,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*RW-1:0] x_rns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*RW-1:0] y_rns,
    output logic             busy,
    output logic             coef_err
);

    state_e           state_q, state_d;
    logic [AW-1:0]    tap_q;
    logic [CH*RW-1:0] dline_q [TAPS];
    logic [CH*RW-1:0] coef_q  [TAPS];
    logic [CH*RW-1:0] y_q;
    logic             coef_err_q;

    logic             accept;
    logic             last_tap;
    logic             mac_en;
    logic             coef_ok;
    logic [CH*RW-1:0] d_sel;
    logic [CH*RW-1:0] c_sel;
    logic [CH*RW-1:0] acc_next;

    assign accept   = in_valid && (state_q == IDLE);
    assign mac_en   = (state_q == MAC);
    assign last_tap = (tap_q == AW'(TAPS - 1));
    assign coef_ok  = coef_we && (state_q == IDLE) && (32'(coef_addr) < TAPS);
    assign d_sel    = dline_q[tap_q];
    assign c_sel    = coef_q[tap_q];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept -> TAPS MAC cycles -> hold result until taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = MAC;
            MAC:     if (last_tap)  state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == MAC);
        out_valid = (state_q == OUT);
    end

    assign y_rns    = y_q;
    assign coef_err = coef_err_q;

    // Delay line, coefficient store, tap counter, result register and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                dline_q[k] <= '0;
                coef_q[k]  <= '0;
            end
            tap_q      <= '0;
            y_q        <= '0;
            coef_err_q <= 1'b0;
        end else begin
            if (coef_ok) begin
                coef_q[coef_addr] <= coef_rns;
            end else if (coef_we) begin
                coef_err_q <= 1'b1;
            end
            if (accept) begin
                for (int k = int'(TAPS) - 1; k > 0; k--) begin
                    dline_q[k] <= dline_q[k-1];
                end
                dline_q[0] <= x_rns;
                tap_q      <= '0;
            end
            if (mac_en) begin
                tap_q <= last_tap ? '0 : tap_q + AW'(1);
                // Capture includes the final tap's contribution.
                if (last_tap) begin
                    y_q <= acc_next;
                end
            end
        end
    end

    for (genvar i = 0; i < int'(CH); i++) begin : g_lane
        rns_mac_lane #(
            .RW (RW),
            .M  (MODULI[i])
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (accept),
            .en       (mac_en),
            .x        (d_sel[i*RW +: RW]),
            .c        (c_sel[i*RW +: RW]),
            .acc_next (acc_next[i*RW +: RW])
        );
    end

endmodule

// File: tb/tb_fir_rns_pipe.sv
// Bench for fir_rns_pipe: integer-domain FIR model checked every cycle plus literal pins.
module tb_fir_rns_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [31:0] coef_rns = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_rns = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y_rns;
    logic        busy;
    logic        coef_err;

    longint coef_int = 0;
    longint x_int = 0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // Model: integer coefficients and samples, and cycles since acceptance (-1 = idle).
    longint mc [6];
    longint md [6];
    int     since = -1;
    bit     m_err = 1'b0;
    longint m_y = 0;
    bit     prev_ov = 1'b0;

    logic [31:0] dut_y_q [$];
    longint      mod_y_q [$];
    int          beat_cyc_q [$];
    int          lat_q [$];

    fir_rns_pipe #(
        .TAPS (6),
        .CH   (4),
        .RW   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_rns  (coef_rns),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_rns     (x_rns),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_rns     (y_rns),
        .busy      (busy),
        .coef_err  (coef_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_rns(input longint v);
        logic [31:0] r;
        longint      mods [4];
        mods = '{233, 239, 241, 251};
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = 8'(v % mods[i]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input longint v);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_int  = v;
        coef_rns  = to_rns(v);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic send(input longint v);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        x_int    = v;
        x_rns    = to_rns(v);
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) timeout("send");
    endtask

    task automatic wait_beats(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (dut_y_q.size() >= n) ok = 1'b1;
        end
        if (!ok) timeout("wait_beats");
    endtask

    // Per-cycle compare against the model, then advance the model on this cycle's inputs.
    initial begin
        for (int k = 0; k < 6; k++) begin
            mc[k] = 0;
            md[k] = 0;
        end
        forever begin
            bit e_ready, e_busy, e_valid;
            @(negedge clk);
            cyc++;
            e_ready = (since < 0);
            e_busy  = (since >= 1) && (since <= 6);
            e_valid = (since == 7);
            chk("in_ready", in_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("out_valid", out_valid, e_valid);
            chk("coef_err", coef_err, m_err);
            if (e_valid) chk("y_rns", y_rns, to_rns(m_y));
            if (out_valid && !prev_ov) lat_q.push_back(cyc - acc_cyc);
            prev_ov = out_valid;
            if (!reset && out_valid && out_ready) begin
                dut_y_q.push_back(y_rns);
                beat_cyc_q.push_back(cyc);
            end
            if (reset) begin
                since = -1;
                m_err = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    mc[k] = 0;
                    md[k] = 0;
                end
            end else begin
                if (coef_we) begin
                    if (since < 0 && coef_addr < 6) mc[coef_addr] = coef_int;
                    else m_err = 1'b1;
                end
                if (since < 0) begin
                    if (in_valid) begin
                        for (int k = 5; k > 0; k--) md[k] = md[k-1];
                        md[0] = x_int;
                        m_y = 0;
                        for (int k = 0; k < 6; k++) m_y += mc[k] * md[k];
                        since   = 1;
                        acc_cyc = cyc;
                    end
                end else if (since <= 6) begin
                    since++;
                end else if (out_ready) begin
                    mod_y_q.push_back(m_y);
                    since = -1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap;
        bit          ok;
        longint      lit1 [10];
        lit1 = '{0, 1, 3, 6, 10, 15, 21, 27, 33, 39};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset y_rns", y_rns, 32'h0);
        chk("reset in_ready", in_ready, 1'b1);

        // Moving sum: all coefficients 1, x = 0..9 back to back.
        for (int k = 0; k < 6; k++) wr(k, 1);
        for (int v = 0; v < 10; v++) send(v);
        wait_beats(10);

        // Single tap wrap: 250 * 250 = 62500.
        wr(0, 250);
        for (int k = 1; k < 6; k++) wr(k, 0);
        send(250);
        wait_beats(11);

        // Backpressure: result held for 5 cycles, then exactly one beat.
        out_ready = 1'b0;
        send(250);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (out_valid) ok = 1'b1;
        end
        if (!ok) timeout("out_valid");
        snap = y_rns;
        chk("bp y literal", snap, 32'h01517938);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp y stable", y_rns, snap);
            chk("bp out_valid", out_valid, 1'b1);
            chk("bp in_ready", in_ready, 1'b0);
        end
        tick();
        out_ready = 1'b1;
        wait_beats(12);
        repeat (3) tick();
        chk("bp one beat", dut_y_q.size(), 12);

        // Illegal coefficient writes: during MAC, and out-of-range address.
        send(2);
        wr(0, 7);
        wait_beats(13);
        wr(6, 5);
        chk("coef_err sticky", coef_err, 1'b1);
        send(1);
        wait_beats(14);

        // Reset in the third MAC cycle abandons the result.
        send(3);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", in_ready, 1'b1);
        chk("post-reset out_valid", out_valid, 1'b0);
        chk("post-reset coef_err", coef_err, 1'b0);
        tick();
        for (int k = 1; k < 6; k++) wr(k, 1);
        // Coefficient write together with a sample: the new c[0] feeds this MAC.
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_int  = 1;
        coef_rns  = to_rns(1);
        send(5);
        coef_we = 1'b0;
        wait_beats(15);
        repeat (4) tick();

        // Literal pins on the collected results.
        chk("beat count", dut_y_q.size(), 15);
        chk("model beat count", mod_y_q.size(), 15);
        if (dut_y_q.size() == 15 && mod_y_q.size() == 15) begin
            for (int n = 0; n < 10; n++) begin
                chk($sformatf("t1 model[%0d]", n), mod_y_q[n], lit1[n]);
                chk($sformatf("t1 dut[%0d]", n), dut_y_q[n], to_rns(lit1[n]));
            end
            chk("wrap model", mod_y_q[10], 62500);
            chk("wrap dut", dut_y_q[10], 32'h01517938);
            chk("bp model", mod_y_q[11], 62500);
            chk("err model", mod_y_q[13], 250);
            chk("err dut", dut_y_q[13], to_rns(250));
            chk("rst model", mod_y_q[14], 5);
            chk("rst dut", dut_y_q[14], to_rns(5));
        end
        if (lat_q.size() > 0) chk("latency", lat_q[0], 7);
        else timeout("latency");
        if (beat_cyc_q.size() >= 10) begin
            for (int n = 0; n < 9; n++) begin
                chk($sformatf("period[%0d]", n), beat_cyc_q[n+1] - beat_cyc_q[n], 8);
            end
        end else begin
            timeout("period");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
